// File: rtl/la_wb_initiator.sv
// la_wb_initiator
// ---------------
// Wishbone classic initiator for programming register-block slaves (LA/GPIO
// mux controllers). A requester hands over one read or write on a
// valid/ready request channel. The block runs exactly one single Wishbone
// cycle for it, then returns the outcome on a valid/ready response channel.
// Only one transaction is outstanding at a time. A slave that never acks is
// cut off after TIMEOUT strobe cycles and reported as an error response.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1. Valid and its payload are held until that
// edge, and ready never depends combinationally on valid.
//
// Ports
//   wb_clk_i, wb_rst_ni       clock, synchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_we_i, req_adr_i,      request: direction, address,
//   req_dat_i, req_sel_i        write data, byte selects
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o      read data (0 for writes/errors), timeout flag
//   wbm_*                     Wishbone classic initiator port
//
// Every output is either a register or a decode of the FSM state combined
// with registers. There is no combinational path from any input to any output.

module la_wb_initiator #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  // request channel
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADR_W-1:0]   req_adr_i,
  input  logic [DAT_W-1:0]   req_dat_i,
  input  logic [DAT_W/8-1:0] req_sel_i,
  // response channel
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DAT_W-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  // Wishbone initiator
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i
);

  localparam int SEL_W = DAT_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last strobe cycle before the timeout fires. The counter stops here, so it
  // never has to hold more than TIMEOUT and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               we_q;
  logic [ADR_W-1:0]   adr_q;
  logic [DAT_W-1:0]   dat_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DAT_W-1:0]   rsp_dat_q;
  logic               rsp_err_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            sel_q   <= req_sel_i;
            cnt_q   <= '0;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          cnt_q <= cnt_d;
          // Ack has priority over the timeout, even on the last strobe cycle.
          if (wbm_ack_i) begin
            rsp_dat_q <= we_q ? '0 : wbm_dat_i;
            rsp_err_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Late or spurious acks are ignored here. The response stays frozen.
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // State decodes
  logic in_bus;
  assign in_bus = (state_q == ST_BUS);

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

  assign wbm_cyc_o   = in_bus;
  assign wbm_stb_o   = in_bus;
  // we/sel are qualified so that the bus never shows a write strobe outside a
  // cycle. adr/dat simply keep their last values.
  assign wbm_we_o    = in_bus & we_q;
  assign wbm_sel_o   = in_bus ? sel_q : '0;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_la_wb_initiator.sv
// Bench for la_wb_initiator (TIMEOUT = 4).
// Each transaction is described at the transaction level:
//   - request fields
//   - which strobe cycle the slave acks on
//   - the read data
// A small model turns that description into the expected strobe length,
// error flag and response data. The transaction is queued, and one monitor
// checks the DUT against the queue head on every falling edge.
module tb_la_wb_initiator;

  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic             wb_clk_i = 1'b0;
  logic             wb_rst_ni;
  logic             req_valid_i, req_ready_o, req_we_i;
  logic [ADR_W-1:0] req_adr_i;
  logic [DAT_W-1:0] req_dat_i;
  logic [SEL_W-1:0] req_sel_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [DAT_W-1:0] rsp_dat_o;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o, wbm_dat_i;

  always #5 wb_clk_i = ~wb_clk_i;

  la_wb_initiator #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [7:0]  ack_dly;   // strobe cycle (0-based) the slave acks on
    logic [31:0] rdata;
    logic [7:0]  nstb;      // expected strobe length
    logic        err;
    logic [31:0] rsp_dat;
  } txn_t;

  txn_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 0;
  bit   spurious = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level rules: the strobe lasts until the ack cycle, but never
  // longer than TIMEOUT cycles. With no ack inside that window the result is
  // an error with zero data. Writes always return zero data.
  function automatic txn_t model(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata);
    txn_t t;
    t.we      = we;
    t.adr     = adr;
    t.dat     = dat;
    t.sel     = sel;
    t.ack_dly = 8'(ack_dly);
    t.rdata   = rdata;
    t.err     = (ack_dly >= TIMEOUT);
    t.nstb    = t.err ? 8'(TIMEOUT) : 8'(ack_dly + 1);
    t.rsp_dat = (t.err || we) ? 32'h0 : rdata;
    return t;
  endfunction

  // ---------------- slave stimulus ----------------
  int s_run = 0;
  always @(negedge wb_clk_i) begin
    wbm_dat_i = $urandom;
    wbm_ack_i = 1'b0;
    if (wbm_stb_o) begin
      if (exp_q.size() > 0 && s_run == int'(exp_q[0].ack_dly)) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = exp_q[0].rdata;
      end
      s_run++;
    end else begin
      s_run     = 0;
      wbm_ack_i = spurious;
    end
  end

  // ---------------- compare process ----------------
  int          m_run = 0;
  logic        m_prev_stb = 1'b0;
  logic [31:0] last_adr = '0;
  logic [31:0] last_dat = '0;

  always @(negedge wb_clk_i) begin
    if (!mon_en) begin
      m_run      = 0;
      m_prev_stb = 1'b0;
      last_adr   = '0;
      last_dat   = '0;
    end else begin
      chk("one_of_ready_stb_rspvalid",
          64'(int'(req_ready_o) + int'(wbm_stb_o) + int'(rsp_valid_o)), 64'd1);
      chk("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
      if (wbm_stb_o) begin
        if (exp_q.size() == 0) chk("unexpected_bus_cycle", 1, 0);
        else begin
          chk("bus_we",  wbm_we_o,  exp_q[0].we);
          chk("bus_adr", wbm_adr_o, exp_q[0].adr);
          chk("bus_dat", wbm_dat_o, exp_q[0].dat);
          chk("bus_sel", wbm_sel_o, exp_q[0].sel);
          last_adr = exp_q[0].adr;
          last_dat = exp_q[0].dat;
          m_run++;
          if (m_run > int'(exp_q[0].nstb)) chk("stb_too_long", 64'(m_run), 64'(exp_q[0].nstb));
        end
      end else begin
        chk("idle_we",  wbm_we_o,  0);
        chk("idle_sel", wbm_sel_o, 0);
        chk("idle_adr_hold", wbm_adr_o, last_adr);
        chk("idle_dat_hold", wbm_dat_o, last_dat);
        if (m_prev_stb && exp_q.size() > 0) chk("stb_len", 64'(m_run), 64'(exp_q[0].nstb));
        m_run = 0;
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          chk("rsp_dat", rsp_dat_o, exp_q[0].rsp_dat);
          chk("rsp_err", rsp_err_o, exp_q[0].err);
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
      m_prev_stb = wbm_stb_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    mon_en      = 0;
    wb_rst_ni   = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    spurious    = 0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    exp_q.delete();
    wb_rst_ni = 1'b1;
    mon_en    = 1;
  endtask

  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata,
                        input int hold, input bit spur,
                        output logic [31:0] got_dat, output logic got_err);
    bit ok;
    got_dat = 'x;
    got_err = 1'bx;
    exp_q.push_back(model(we, adr, dat, sel, ack_dly, rdata));
    @(posedge wb_clk_i);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_sel_i   = sel;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin chk("req_accept_timeout", 0, 1); reset_dut(); return; end
    @(posedge wb_clk_i);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom);
    req_adr_i   = $urandom;
    req_dat_i   = $urandom;
    req_sel_i   = 4'($urandom);
    @(negedge wb_clk_i);
    chk("bus_latency_1", wbm_stb_o, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid_o) begin ok = 1; break; end
      @(negedge wb_clk_i);
    end
    if (!ok) begin chk("rsp_wait_timeout", 0, 1); reset_dut(); return; end
    got_dat  = rsp_dat_o;
    got_err  = rsp_err_o;
    spurious = spur;
    repeat (hold) @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    #1;
    rsp_ready_i = 1'b1;
    spurious    = 0;
    @(posedge wb_clk_i);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rsp_valid_drop", rsp_valid_o, 0);
    chk("ready_after_rsp", req_ready_o, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    txn_t        t;
    logic [31:0] gd;
    logic        ge;
    bit          seen_rsp;

    wb_rst_ni   = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_adr_i   = '0;
    req_dat_i   = '0;
    req_sel_i   = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we",  wbm_we_o,  0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    mon_en    = 1;

    // Pin the model with hand-computed values (TIMEOUT = 4).
    t = model(1'b1, 32'h0, 32'h0, 4'hF, 2, 32'hDEAD_BEEF);
    chk("model_write_nstb", t.nstb, 3);
    chk("model_write_dat", t.rsp_dat, 0);
    t = model(1'b0, 32'h0, 32'h0, 4'hF, 99, 32'h1111_2222);
    chk("model_to_nstb", t.nstb, 4);
    chk("model_to_err", t.err, 1);
    t = model(1'b0, 32'h0, 32'h0, 4'hF, 3, 32'h1111_2222);
    chk("model_coinc_err", t.err, 0);
    chk("model_coinc_dat", t.rsp_dat, 32'h1111_2222);

    // Directed cases
    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_0F0F, 4'hF, 2, 32'hDEAD_BEEF, 0, 0, gd, ge);
    chk("tp_write_dat", gd, 32'h0);
    chk("tp_write_err", ge, 0);
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h1234_5678, 0, 0, gd, ge);
    chk("tp_read_dat", gd, 32'h1234_5678);
    chk("tp_read_err", ge, 0);
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 99, 32'h7777_7777, 0, 0, gd, ge);
    chk("tp_timeout_err", ge, 1);
    chk("tp_timeout_dat", gd, 32'h0);
    do_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 1, 32'h5555_AAAA, 0, 0, gd, ge);
    chk("tp_after_timeout_dat", gd, 32'h5555_AAAA);
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 5, 1, gd, ge);
    chk("tp_backpressure_dat", gd, 32'hCAFE_F00D);
    do_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 3, 32'h0BAD_F00D, 0, 0, gd, ge);
    chk("tp_coinc_err", ge, 0);
    chk("tp_coinc_dat", gd, 32'h0BAD_F00D);

    // Randomized traffic; ack delays 4..5 time out, 3 hits the last cycle.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 5), $urandom,
             $urandom_range(0, 3), 1'($urandom), gd, ge);
    end

    // Reset during BUS: the transaction vanishes without a response.
    exp_q.push_back(model(1'b0, 32'h3000_0020, 32'h0, 4'hF, 99, 32'h0));
    @(posedge wb_clk_i);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_adr_i   = 32'h3000_0020;
    req_sel_i   = 4'hF;
    @(posedge wb_clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge wb_clk_i);
    chk("mid_bus_stb", wbm_stb_o, 1);
    mon_en    = 0;
    wb_rst_ni = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_stb", wbm_stb_o, 0);
    chk("mid_rst_rsp_valid", rsp_valid_o, 0);
    exp_q.delete();
    wb_rst_ni = 1'b1;
    mon_en    = 1;
    @(negedge wb_clk_i);
    chk("mid_rst_req_ready", req_ready_o, 1);
    seen_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      if (rsp_valid_o) seen_rsp = 1;
    end
    chk("mid_rst_no_rsp", seen_rsp, 0);
    do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 0, 32'h600D_600D, 0, 0, gd, ge);
    chk("post_rst_read_dat", gd, 32'h600D_600D);

    repeat (2) @(posedge wb_clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
